// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// funct3 codes, FSM state encoding and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP
  } state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(
    input logic [2:0] f3
  );
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/load_store_unit_t_lane_align.sv
// Byte-lane alignment helper shared by both bus beats.
// Gives the beat's write mask and the bit shift for data lanes.
module lane_align_t #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                size_log,
  input  logic                      beat,
  output logic [XLEN/8-1:0]         wmask,
  output logic [$clog2(XLEN):0]     wshift,
  output logic [$clog2(XLEN):0]     rshift
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [7:0]         len;
  logic [2*BYTES-1:0] span;
  logic [OFF_W:0]     amt;

  // Two-word byte span of the access; each beat takes its half.
  always_comb begin
    len = 8'h00;
    unique case (size_log)
      2'd0:    len = 8'h01;
      2'd1:    len = 8'h03;
      2'd2:    len = 8'h0F;
      default: len = 8'hFF;
    endcase
    span = (2*BYTES)'(len) << off;
    if (beat) begin
      wmask = span[2*BYTES-1:BYTES];
      amt   = (OFF_W+1)'(BYTES) - {1'b0, off};
    end else begin
      wmask = span[BYTES-1:0];
      amt   = {1'b0, off};
    end
    wshift = {amt, 3'b000};
    rshift = {amt, 3'b000};
  end

endmodule

// File: rtl/load_store_unit_t.sv
// Load/store unit: execute stage to word-aligned data bus.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses in two beats.
module load_store_unit_t
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_fault,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SH_W  = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   merged_q, merged_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic              cross;
`else
  logic              misal;
`endif

  logic [3:0]        nb;
  logic              illegal;
  logic              fault;
  logic              beat;
  logic              busy;
  logic [BYTES-1:0]  wmask;
  logic [SH_W-1:0]   wsh;
  logic [SH_W-1:0]   rsh;
  logic [ADDR_W-1:0] base;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   ext;
  logic              sb;
  int                nbits;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign beat = (state_q == S_BEAT1);
  assign busy = (state_q == S_BEAT0) ||
                (state_q == S_BEAT1);
`else
  assign beat = 1'b0;
  assign busy = (state_q == S_BEAT0);
`endif

  lane_align_t #(.XLEN(XLEN)) u_align (
    .off      (addr_q[OFF_W-1:0]),
    .size_log (f3_q[1:0]),
    .beat     (beat),
    .wmask    (wmask),
    .wshift   (wsh),
    .rshift   (rsh)
  );

  // Classify the incoming request: legality and lane crossing.
  always_comb begin
    nb      = size_bytes(req_funct3);
    illegal = (req_funct3 == 3'd7) ||
              (req_write && req_funct3[2]) ||
              ((XLEN == 32) &&
               (req_funct3 == F3_D ||
                req_funct3 == F3_WU));
`ifdef LSU_MISALIGN_SPLIT_EN
    cross = (5'(req_addr[OFF_W-1:0]) + 5'(nb))
            > 5'(BYTES);
    fault = illegal;
`else
    misal = (req_addr[3:0] & (nb - 4'd1)) != 4'd0;
    fault = illegal || misal;
`endif
  end

  // Bus-side outputs are derived from the registered request.
  always_comb begin
    base      = {addr_q[ADDR_W-1:OFF_W],
                 {OFF_W{1'b0}}};
    mem_req   = busy;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_addr = beat ? base + ADDR_W'(BYTES) : base;
      if (write_q) begin
        mem_wmask = wmask;
        mem_wdata = beat ? wdata_q >> wsh
                         : wdata_q << wsh;
      end
    end
  end

  // Merge read lanes and extend to the access size.
  always_comb begin
    rd_word = beat ? merged_q | (mem_rdata << rsh)
                   : mem_rdata >> rsh;
    sb = 1'b0;
    unique case (f3_q[1:0])
      2'd0:    sb = rd_word[7];
      2'd1:    sb = rd_word[15];
      2'd2:    sb = rd_word[31];
      default: sb = rd_word[XLEN-1];
    endcase
    nbits = 8 << f3_q[1:0];
    ext   = '0;
    for (int i = 0; i < XLEN; i++) begin
      ext[i] = (i < nbits) ? rd_word[i]
                           : (~f3_q[2] & sb);
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merged_d    = merged_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d     = split_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          f3_d     = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          merged_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d  = cross;
`endif
          if (fault) begin
            state_d     = S_RESP;
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = S_BEAT0;
          end
        end
      end
      S_BEAT0: begin
        if (mem_ack) begin
          merged_d = rd_word;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) state_d = S_BEAT1;
          else
`endif
          begin
            state_d     = S_RESP;
            rsp_fault_d = 1'b0;
            rsp_data_d  = write_q ? '0 : ext;
          end
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_BEAT1: begin
        if (mem_ack) begin
          merged_d    = rd_word;
          state_d     = S_RESP;
          rsp_fault_d = 1'b0;
          rsp_data_d  = write_q ? '0 : ext;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merged_q    <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merged_q    <= merged_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= split_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit_t.sv
// Directed bench for load_store_unit_t, XLEN 32 and 64 instances.
// Expected values are hand-computed constants.
module tb_load_store_unit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v32, v64, wr, ack;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wd, rdata;

  logic        rdy32, rv32, rf32, mq32;
  logic [31:0] rd32, ma32, wdt32;
  logic [3:0]  wm32;
  logic        rdy64, rv64, rf64, mq64;
  logic [63:0] rd64, wdt64;
  logic [31:0] ma64;
  logic [7:0]  wm64;

  load_store_unit_t #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(rst),
    .req_valid(v32), .req_ready(rdy32),
    .req_write(wr), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wd[31:0]),
    .rsp_valid(rv32), .rsp_data(rd32),
    .rsp_fault(rf32), .mem_req(mq32),
    .mem_ack(ack), .mem_addr(ma32),
    .mem_wmask(wm32), .mem_wdata(wdt32),
    .mem_rdata(rdata[31:0])
  );

  load_store_unit_t #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(rst),
    .req_valid(v64), .req_ready(rdy64),
    .req_write(wr), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wd),
    .rsp_valid(rv64), .rsp_data(rd64),
    .rsp_fault(rf64), .mem_req(mq64),
    .mem_ack(ack), .mem_addr(ma64),
    .mem_wmask(wm64), .mem_wdata(wdt64),
    .mem_rdata(rdata)
  );

  bit          sel64;
  logic        o_rdy, o_rv, o_fault, o_mreq;
  logic [63:0] o_data, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_mask;

  // Observe whichever instance the current transaction targets.
  always_comb begin
    o_rdy   = sel64 ? rdy64 : rdy32;
    o_rv    = sel64 ? rv64 : rv32;
    o_fault = sel64 ? rf64 : rf32;
    o_mreq  = sel64 ? mq64 : mq32;
    o_data  = sel64 ? rd64 : {32'd0, rd32};
    o_wdata = sel64 ? wdt64 : {32'd0, wdt32};
    o_addr  = sel64 ? ma64 : ma32;
    o_mask  = sel64 ? wm64 : {4'd0, wm32};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  int          nb, rsp_cyc, ack_cyc, req_first;
  bit          any_req, unstable, got_rsp;
  logic [31:0] b_addr [2];
  logic [7:0]  b_mask [2];
  logic [63:0] b_wd   [2];
  logic [63:0] r_data;
  logic        r_fault;

  task automatic txn(input bit s64, input bit w,
                     input logic [2:0] fn,
                     input logic [31:0] a,
                     input logic [63:0] d,
                     input int waits,
                     input logic [63:0] rd0,
                     input logic [63:0] rd1);
    int wc;
    int cyc;
    sel64 = s64;
    nb = 0; any_req = 0; unstable = 0;
    got_rsp = 0; ack_cyc = -1;
    req_first = -1; rsp_cyc = -1;
    r_data = '0; r_fault = 1'b0;
    wr = w; f3 = fn; addr = a; wd = d;
    if (s64) v64 = 1'b1;
    else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    wc = 0; cyc = 0;
    while (cyc < 40 && !got_rsp) begin
      if (o_rv) begin
        got_rsp = 1;
        r_data  = o_data;
        r_fault = o_fault;
        rsp_cyc = cyc;
      end else begin
        if (o_mreq) begin
          if (!any_req) req_first = cyc;
          any_req = 1;
          if (nb < 2) begin
            if (wc == 0) begin
              b_addr[nb] = o_addr;
              b_mask[nb] = o_mask;
              b_wd[nb]   = o_wdata;
            end else if (o_addr !== b_addr[nb] ||
                         o_mask !== b_mask[nb] ||
                         o_wdata !== b_wd[nb]) begin
              unstable = 1;
            end
          end
          if (wc == waits) begin
            ack = 1'b1;
            rdata = (nb == 0) ? rd0 : rd1;
          end else begin
            wc++;
          end
        end
        @(negedge clk);
        cyc++;
        if (ack) begin
          ack = 1'b0;
          nb++;
          wc = 0;
          ack_cyc = cyc;
        end
      end
    end
    chk("rsp_seen", got_rsp, 1);
    @(negedge clk);
    chk("rsp_pulse", o_rv, 0);
    chk("ready_back", o_rdy, 1);
    chk("rsp_hold", o_data, r_data);
  endtask

  bit seen;

  initial begin
    rst = 1'b1; v32 = 1'b0; v64 = 1'b0;
    wr = 1'b0; f3 = 3'd0; addr = '0;
    wd = '0; ack = 1'b0; rdata = '0;
    sel64 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy32, 1);
    chk("rst_rv", rv32, 0);
    chk("rst_data", rd32, 0);
    chk("rst_fault", rf32, 0);
    chk("rst_mreq", mq32, 0);
    chk("rst_maddr", ma32, 0);
    chk("rst_mask", wm32, 0);
    chk("rst_wdata", wdt32, 0);
    chk("rst_ready64", rdy64, 1);
    rst = 1'b0;
    @(negedge clk);

    // LW aligned, two wait cycles
    txn(0, 0, 3'd2, 32'h100, 0, 2,
        64'h8000_00F0, 0);
    chk("lw_addr", b_addr[0], 32'h100);
    chk("lw_mask", b_mask[0], 0);
    chk("lw_data", r_data, 64'h8000_00F0);
    chk("lw_fault", r_fault, 0);
    chk("lw_beats", nb, 1);
    chk("lw_first", req_first, 0);
    chk("lw_lat", rsp_cyc, 3);
    chk("lw_stable", unstable, 0);

    // SB to top byte
    txn(0, 1, 3'd0, 32'h203, 64'hAB, 1, 0, 0);
    chk("sb_addr", b_addr[0], 32'h200);
    chk("sb_mask", b_mask[0], 8'h08);
    chk("sb_byte", b_wd[0][31:24], 8'hAB);
    chk("sb_data", r_data, 0);
    chk("sb_stable", unstable, 0);

    txn(0, 0, 3'd0, 32'h203, 0, 0,
        64'hAB00_0000, 0);
    chk("lb_data", r_data, 64'hFFFF_FFAB);
    chk("lb_lat", rsp_cyc, 1);
    txn(0, 0, 3'd4, 32'h203, 0, 0,
        64'hAB00_0000, 0);
    chk("lbu_data", r_data, 64'h0000_00AB);

    // LH aligned, sign bit set
    txn(0, 0, 3'd1, 32'h102, 0, 0,
        64'h8001_0000, 0);
    chk("lh_data", r_data, 64'hFFFF_8001);

    // Crossing LW and SH
    txn(0, 0, 3'd2, 32'h102, 0, 0,
        64'h1122_3344, 64'h5566_7788);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("xlw_beats", nb, 2);
    chk("xlw_addr0", b_addr[0], 32'h100);
    chk("xlw_addr1", b_addr[1], 32'h104);
    chk("xlw_data", r_data, 64'h7788_1122);
    chk("xlw_fault", r_fault, 0);
`else
    chk("xlw_fault", r_fault, 1);
    chk("xlw_data", r_data, 0);
    chk("xlw_noreq", any_req, 0);
    chk("xlw_lat", rsp_cyc, 0);
`endif
    txn(0, 1, 3'd1, 32'h0FF, 64'hBEEF, 1, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("xsh_addr0", b_addr[0], 32'h0FC);
    chk("xsh_mask0", b_mask[0], 8'h08);
    chk("xsh_byte0", b_wd[0][31:24], 8'hEF);
    chk("xsh_addr1", b_addr[1], 32'h100);
    chk("xsh_mask1", b_mask[1], 8'h01);
    chk("xsh_byte1", b_wd[1][7:0], 8'hBE);
`else
    chk("xsh_fault", r_fault, 1);
    chk("xsh_noreq", any_req, 0);
`endif

    // Illegal encodings
    txn(0, 0, 3'd3, 32'h0, 0, 0, 0, 0);
    chk("ld32_fault", r_fault, 1);
    chk("ld32_data", r_data, 0);
    chk("ld32_noreq", any_req, 0);
    txn(0, 1, 3'd4, 32'h0, 64'h5, 0, 0, 0);
    chk("sbu_fault", r_fault, 1);
    txn(0, 0, 3'd7, 32'h0, 0, 0, 0, 0);
    chk("f37_fault", r_fault, 1);

    // XLEN=64 accesses
    txn(1, 0, 3'd3, 32'h8, 0, 1,
        64'h0123_4567_89AB_CDEF, 0);
    chk("ld_addr", b_addr[0], 32'h8);
    chk("ld_data", r_data,
        64'h0123_4567_89AB_CDEF);
    chk("ld_fault", r_fault, 0);
    txn(1, 0, 3'd6, 32'hC, 0, 0,
        64'h0123_4567_89AB_CDEF, 0);
    chk("lwu_addr", b_addr[0], 32'h8);
    chk("lwu_data", r_data,
        64'h0000_0000_0123_4567);
    txn(1, 0, 3'd2, 32'hC, 0, 0,
        64'h8000_0000_0000_0000, 0);
    chk("lw64_data", r_data,
        64'hFFFF_FFFF_8000_0000);
    txn(1, 1, 3'd2, 32'h4, 64'h1122_3344, 0,
        0, 0);
    chk("sw64_mask", b_mask[0], 8'hF0);
    chk("sw64_wdata", b_wd[0],
        64'h1122_3344_0000_0000);

    // Reset during BEAT0
    sel64 = 0;
    wr = 0; f3 = 3'd2; addr = 32'h300;
    v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    chk("mid_req", mq32, 1);
    rst = 1'b1;
    #1;
    chk("mid_drop", mq32, 0);
    chk("mid_rv", rv32, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", rdy32, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rv32) seen = 1;
    end
    chk("mid_norsp", seen, 0);
    txn(0, 0, 3'd2, 32'h40, 0, 1,
        64'h1234_5678, 0);
    chk("post_data", r_data, 64'h1234_5678);
    chk("post_lat", rsp_cyc, 2);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
